// File: rtl/ahb_master_if.sv
// Command/response handshake and AHB-Lite signals seen by the ahb_master initiator.
// The master modport is the initiator's view; the slave modport is the far side (host + AHB slave).
interface ahb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_error;
  logic [31:0] rsp_rdata;
  logic        busy;

  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_write, rsp_error, rsp_rdata, busy,
    output hsel, haddr, htrans, hsize, hwrite, hburst, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_write, rsp_error, rsp_rdata, busy,
    input  hsel, haddr, htrans, hsize, hwrite, hburst, hwdata
  );
endinterface

// File: rtl/ahb_master.sv
// AHB-Lite initiator: queues command words and issues them as pipelined SINGLE/NONSEQ
// transfers, honouring wait states and the two-cycle ERROR response.
module ahb_master #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  ahb_master_if.master bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic        write;
    logic [3:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  // Data-phase tracker; CANCEL is the second error cycle, where address phase is withdrawn.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_CANCEL = 2'd2
  } dp_state_e;

  dp_state_e        state, state_n;
  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_n, count_rem;
  cmd_t             cmd_in, head, head_n;
  logic             push, pop, issue_n, dphase_n, rsp_fire;

  logic             cmd_ready_q, busy_q, hsel_q, hwrite_q, dp_write_q;
  logic [1:0]       htrans_q, hsize_q;
  logic [3:0]       haddr_q;
  logic [31:0]      hwdata_q;
  logic             rsp_valid_q, rsp_write_q, rsp_error_q;
  logic [31:0]      rsp_rdata_q;

  // Queue bookkeeping and the command that will sit at the head after this edge
  always_comb begin
    cmd_in    = {bus.cmd_write, bus.cmd_addr, bus.cmd_size, bus.cmd_wdata};
    head      = mem[rd_ptr];
    push      = bus.cmd_valid && cmd_ready_q;
    pop       = (htrans_q == HTRANS_NONSEQ) && bus.hready;
    count_n   = count + CNT_W'(push) - CNT_W'(pop);
    count_rem = count - CNT_W'(pop);
    head_n    = (count_rem == '0) ? cmd_in : mem[rd_ptr + PTR_W'(pop)];
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_n;
  end

  // FSM next state and next-cycle bus decode
  always_comb begin
    state_n  = state;
    issue_n  = 1'b0;
    dphase_n = 1'b0;
    rsp_fire = 1'b0;
    case (state)
      ST_IDLE:   if (pop) state_n = ST_DATA;
      ST_DATA: begin
        if (bus.hready)    state_n = pop ? ST_DATA : ST_IDLE;
        else if (bus.hresp) state_n = ST_CANCEL;
      end
      ST_CANCEL: if (bus.hready) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    rsp_fire = (state != ST_IDLE) && bus.hready;
    dphase_n = (state_n != ST_IDLE);
    issue_n  = (count_n != '0) && (state_n != ST_CANCEL);
  end

  // Queue storage carries no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // Pointers, registered bus outputs and response
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      hsel_q      <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      dp_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_n;
      cmd_ready_q <= (count_n != CNT_W'(FIFO_DEPTH));
      busy_q      <= (count_n != '0) || dphase_n;
      hsel_q      <= issue_n || dphase_n;
      htrans_q    <= issue_n ? HTRANS_NONSEQ : HTRANS_IDLE;
      haddr_q     <= issue_n ? head_n.addr : 4'd0;
      hsize_q     <= issue_n ? head_n.size : 2'd0;
      hwrite_q    <= issue_n ? head_n.write : 1'b0;
      if (pop) begin
        hwdata_q   <= head.write ? head.wdata : 32'd0;
        dp_write_q <= head.write;
      end
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_write_q <= dp_write_q;
        rsp_error_q <= bus.hresp;
        rsp_rdata_q <= dp_write_q ? 32'd0 : bus.hrdata;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.hsel      = hsel_q;
  assign bus.htrans    = htrans_q;
  assign bus.haddr     = haddr_q;
  assign bus.hsize     = hsize_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hburst    = 3'b000;
  assign bus.hwdata    = hwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: inputs driven and outputs checked on the falling edge,
// slave responses hand-scripted per cycle.
module tb_ahb_master;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  ahb_master_if bus ();

  ahb_master #(.FIFO_DEPTH(4)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input logic w, input logic [3:0] a, input logic [1:0] s,
                           input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
  endtask

  initial begin
    n_rst         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 4'd0;
    bus.cmd_size  = 2'd0;
    bus.cmd_wdata = 32'd0;
    bus.hrdata    = 32'd0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;
    repeat (2) cyc();

    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_hsel",      bus.hsel,      0);
    chk("rst_htrans",    bus.htrans,    0);
    chk("rst_haddr",     bus.haddr,     0);
    chk("rst_hwdata",    bus.hwdata,    0);
    chk("rst_hburst",    bus.hburst,    0);
    n_rst = 1'b1;
    cyc();

    // single word write, zero wait states
    drive_cmd(1'b1, 4'd0, 2'd2, 32'hDEAD_BEEF);
    cyc();
    bus.cmd_valid = 1'b0;
    chk("wr_htrans", bus.htrans, 2);
    chk("wr_haddr",  bus.haddr,  0);
    chk("wr_hsize",  bus.hsize,  2);
    chk("wr_hwrite", bus.hwrite, 1);
    chk("wr_hsel",   bus.hsel,   1);
    chk("wr_busy",   bus.busy,   1);
    cyc();
    chk("wr_hwdata",     bus.hwdata,    32'hDEAD_BEEF);
    chk("wr_dp_htrans",  bus.htrans,    0);
    chk("wr_dp_hsel",    bus.hsel,      1);
    chk("wr_dp_rsp",     bus.rsp_valid, 0);
    cyc();
    chk("wr_rsp_valid",  bus.rsp_valid, 1);
    chk("wr_rsp_write",  bus.rsp_write, 1);
    chk("wr_rsp_error",  bus.rsp_error, 0);
    chk("wr_rsp_rdata",  bus.rsp_rdata, 0);
    chk("wr_busy_done",  bus.busy,      0);
    cyc();
    chk("wr_rsp_pulse",  bus.rsp_valid, 0);

    // single read from addr 8
    drive_cmd(1'b0, 4'd8, 2'd2, 32'hFFFF_FFFF);
    cyc();
    bus.cmd_valid = 1'b0;
    chk("rd_htrans", bus.htrans, 2);
    chk("rd_haddr",  bus.haddr,  8);
    chk("rd_hwrite", bus.hwrite, 0);
    cyc();
    bus.hrdata = 32'h0000_0040;
    chk("rd_hwdata", bus.hwdata, 0);
    cyc();
    bus.hrdata = 32'd0;
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_write", bus.rsp_write, 0);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'h0000_0040);
    cyc();

    // four back-to-back writes, pipelined one per cycle
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive_cmd(1'b1, 4'(4 * i), 2'd2, 32'h1000_0000 + 32'(i));
      else       bus.cmd_valid = 1'b0;
      cyc();
      chk("b2b_cmd_ready", bus.cmd_ready, 1);
      if (i < 4) begin
        chk("b2b_htrans", bus.htrans, 2);
        chk("b2b_haddr",  bus.haddr,  32'(4 * i));
      end
      if (i >= 1 && i <= 4) chk("b2b_hwdata", bus.hwdata, 32'h1000_0000 + 32'(i - 1));
      if (i >= 2) begin
        chk("b2b_rsp_valid", bus.rsp_valid, 1);
        chk("b2b_rsp_write", bus.rsp_write, 1);
      end else begin
        chk("b2b_rsp_early", bus.rsp_valid, 0);
      end
    end
    cyc();
    chk("b2b_idle", bus.busy, 0);

    // three wait states on write to 12 with read of 8 queued
    drive_cmd(1'b1, 4'd12, 2'd2, 32'hCAFE_0012);
    cyc();
    drive_cmd(1'b0, 4'd8, 2'd2, 32'd0);
    cyc();
    bus.cmd_valid = 1'b0;
    bus.hready    = 1'b0;
    chk("ws_haddr_w1", bus.haddr, 8);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ws_htrans_held", bus.htrans, 2);
      chk("ws_haddr_held",  bus.haddr,  8);
      chk("ws_hwrite_held", bus.hwrite, 0);
      chk("ws_hwdata_held", bus.hwdata, 32'hCAFE_0012);
      chk("ws_rsp_wait",    bus.rsp_valid, 0);
    end
    bus.hready = 1'b1;
    cyc();
    bus.hrdata = 32'h0000_0055;
    chk("ws_wr_rsp",       bus.rsp_valid, 1);
    chk("ws_wr_rsp_write", bus.rsp_write, 1);
    chk("ws_htrans_idle",  bus.htrans,    0);
    cyc();
    bus.hrdata = 32'd0;
    chk("ws_rd_rsp",       bus.rsp_valid, 1);
    chk("ws_rd_rsp_write", bus.rsp_write, 0);
    chk("ws_rd_rdata",     bus.rsp_rdata, 32'h0000_0055);
    cyc();

    // ERROR on byte write to 5, queued read of 8 cancelled then reissued
    drive_cmd(1'b1, 4'd5, 2'd0, 32'h0000_00AB);
    cyc();
    chk("er_hsize", bus.hsize, 0);
    chk("er_haddr", bus.haddr, 5);
    drive_cmd(1'b0, 4'd8, 2'd2, 32'd0);
    cyc();
    bus.cmd_valid = 1'b0;
    bus.hresp     = 1'b1;
    bus.hready    = 1'b0;
    chk("er_e_htrans", bus.htrans, 2);
    cyc();
    bus.hready = 1'b1;
    chk("er_cancel_htrans", bus.htrans,    0);
    chk("er_cancel_hsel",   bus.hsel,      1);
    chk("er_cancel_rsp",    bus.rsp_valid, 0);
    cyc();
    bus.hresp = 1'b0;
    chk("er_rsp_valid",    bus.rsp_valid, 1);
    chk("er_rsp_error",    bus.rsp_error, 1);
    chk("er_rsp_write",    bus.rsp_write, 1);
    chk("er_reissue",      bus.htrans,    2);
    chk("er_reissue_addr", bus.haddr,     8);
    cyc();
    bus.hrdata = 32'h0000_1234;
    cyc();
    bus.hrdata = 32'd0;
    chk("er_rd_rsp",   bus.rsp_valid, 1);
    chk("er_rd_error", bus.rsp_error, 0);
    chk("er_rd_rdata", bus.rsp_rdata, 32'h0000_1234);
    cyc();

    // fill queue against a stalled slave, then reset mid-stall
    bus.hready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 4'(i + 1), 2'd2, 32'(i));
      cyc();
      chk("full_cmd_ready", bus.cmd_ready, (i < 3) ? 1 : 0);
    end
    drive_cmd(1'b1, 4'd15, 2'd2, 32'hFFFF_FFFF);
    cyc();
    chk("full_still_full", bus.cmd_ready, 0);
    chk("full_head_addr",  bus.haddr,     1);
    chk("full_htrans",     bus.htrans,    2);
    chk("full_busy",       bus.busy,      1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_htrans",    bus.htrans,    0);
    chk("mid_rst_busy",      bus.busy,      0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    chk("mid_rst_hsel",      bus.hsel,      0);
    bus.cmd_valid = 1'b0;
    bus.hready    = 1'b1;
    cyc();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_rsp",    bus.rsp_valid, 0);
      chk("post_rst_htrans", bus.htrans,    0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
